alu_arbiter: RTL

Shares one instance of the team's 8-bit `alu` datapath between two independent requesters. Each requester has a valid/ready request channel carrying op, A and B, and a valid/ready response channel returning D and the carry. Only one operation is in flight at a time. Grants are round-robin (or fixed-priority, set by a parameter), and operands and results are registered around the combinational ALU.

---
 rtl/alu_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit alu between two valid/ready requesters.
// Only one operation is in flight: IDLE accepts a request, EXEC latches the
// ALU result, RESP presents it to the owning port until that port takes it.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready        request handshake (ready is combinational)
//   req{0,1}_op/_a/_b            ALU select and operands per port
//   rsp{0,1}_valid/_ready        response handshake per port
//   rsp_d, rsp_c                 shared result byte and carry
//   busy                         high whenever the FSM is not in IDLE
//
// Parameter FAIR: 1 = round-robin on contention, 0 = port 0 always wins.

// alu: combinational 8-bit datapath, S selects the operation.
module alu (
  input  logic [2:0] s,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] d,
  output logic       c
);

  localparam int unsigned DW = 8;

  logic [DW:0] r;

  // 9-bit result; bit 8 is the carry/borrow/shifted-out bit.
  always_comb begin
    r = '0;
    unique case (s)
      3'b000: r = {1'b0, a} + {1'b0, b};
      3'b001: r = {1'b0, a} - {1'b0, b};
      3'b010: r = {1'b0, a & b};
      3'b011: r = {1'b0, a | b};
      3'b100: r = {1'b0, a} << b;
      3'b101: r = {1'b0, a >> b};
      3'b110: r = {1'b0, a ^ b};
      3'b111: r = {1'b0, ~a};
      default: r = '0;
    endcase
  end

  assign d = r[DW-1:0];
  assign c = r[DW];

endmodule

module alu_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp_d,
  output logic       rsp_c,
  output logic       busy
);

  localparam int unsigned OPW = 3;
  localparam int unsigned DW  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            owner_q, owner_d;
  logic            prio_q, prio_d;
  logic [DW-1:0]   d_q, d_d;
  logic            c_q, c_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic            busy_q, busy_d;

  logic            any_valid;
  logic            sel;
  logic            grant0, grant1;
  logic            owner_rsp_ready;
  logic [DW-1:0]   alu_d;
  logic            alu_c;

  // Shared datapath, fed only from the captured operands.
  alu u_alu (
    .s (op_q),
    .a (a_q),
    .b (b_q),
    .d (alu_d),
    .c (alu_c)
  );

  // Port selection: a lone requester wins; on contention prio_q decides
  // when fair, otherwise port 0.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      sel = FAIR ? prio_q : 1'b0;
    end else begin
      sel = req1_valid;
    end
  end

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    d_d     = d_q;
    c_d     = c_q;
    grant0  = 1'b0;
    grant1  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant0  = ~sel;
          grant1  = sel;
          op_d    = sel ? req1_op : req0_op;
          a_d     = sel ? req1_a  : req0_a;
          b_d     = sel ? req1_b  : req0_b;
          owner_d = sel;
          prio_d  = FAIR ? ~sel : 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        d_d     = alu_d;
        c_d     = alu_c;
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rsp0_valid_d = (state_d == RESP) && !owner_d;
    rsp1_valid_d = (state_d == RESP) &&  owner_d;
    busy_d       = (state_d != IDLE);
  end

  // Ready is combinational; gating with rst_n keeps it low during reset.
  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b0;
      prio_q       <= 1'b0;
      d_q          <= '0;
      c_q          <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      prio_q       <= prio_d;
      d_q          <= d_d;
      c_q          <= c_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_d      = d_q;
  assign rsp_c      = c_q;
  assign busy       = busy_q;

endmodule
